// File: rtl/dm_pkg.sv
// Shared encodings, state type and size helper for the clocked data memory controller.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Number of bytes touched by an access of the given size (illegal size reports 4).
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Word-organised RAM with four independently writable byte lanes and a combinational read.
module dm_byte_ram #(
    parameter int WORDS = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [WORDS];

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/data_memory_ctrl.sv
// Clocked byte-addressed data memory with wait states, alignment/range checking
// and sign/zero-extended sub-word loads behind a request/acknowledge handshake.
module data_memory_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic              busy_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [31:0]       data_o
);

    localparam int         LOC_W = $clog2(DEPTH_BYTES);
    localparam int         WORDS = DEPTH_BYTES / 4;
    localparam int         IDX_W = (LOC_W > 2) ? LOC_W - 2 : 1;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    // Sub-word load extraction and extension to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = raw[7:0];
        h = raw[15:0];
        case (size)
            SZ_BYTE: extend_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: extend_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: extend_load = raw;
        endcase
    endfunction

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              ack_q;
    logic              err_q;
    logic [31:0]       load_q;

    logic [LOC_W-1:0]  addr_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              req_err;
    logic              fire;
    logic [ADDR_W:0]   end_addr;

    logic [LOC_W-1:0]  acc_addr;
    logic              acc_we;
    logic [1:0]        acc_size;
    logic              acc_uns;
    logic [31:0]       acc_wdata;
    logic [1:0]        acc_off;

    logic [IDX_W-1:0]  ram_idx;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       load_raw;

    assign accept   = (state_q == IDLE) && req_i;
    assign end_addr = {1'b0, addr_i} + (ADDR_W+1)'(size_bytes(size_i));
    assign req_err  = (size_i == 2'b11)
                   || ((size_i == SZ_HALF) && addr_i[0])
                   || ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00))
                   || (end_addr > (ADDR_W+1)'(DEPTH_BYTES));

    // A zero-latency access completes on its acceptance edge, so it uses the live
    // inputs; every other access completes from the latched copy.
    assign fire = (accept && !req_err && (LATENCY == 0))
               || ((state_q == WAIT) && !ack_q && (cnt_q == 4'd1));

    assign acc_addr  = (state_q == IDLE) ? addr_i[LOC_W-1:0] : addr_q;
    assign acc_we    = (state_q == IDLE) ? we_i              : we_q;
    assign acc_size  = (state_q == IDLE) ? size_i            : size_q;
    assign acc_uns   = (state_q == IDLE) ? unsigned_i        : uns_q;
    assign acc_wdata = (state_q == IDLE) ? data_i            : wdata_q;
    assign acc_off   = acc_addr[1:0];

    assign ram_idx  = IDX_W'(acc_addr >> 2);
    // Reset wins over a completion on the same edge, so a pending store is dropped.
    assign ram_we   = fire && acc_we && rst_i;
    assign load_raw = ram_rdata >> {acc_off, 3'b000};

    // Store lane steering: replicate the low bytes across lanes and enable the addressed ones.
    always_comb begin
        ram_be    = 4'b1111;
        ram_wdata = acc_wdata;
        case (acc_size)
            SZ_BYTE: begin
                ram_be    = 4'b0001 << acc_off;
                ram_wdata = {4{acc_wdata[7:0]}};
            end
            SZ_HALF: begin
                ram_be    = 4'b0011 << acc_off;
                ram_wdata = {2{acc_wdata[15:0]}};
            end
            default: begin
                ram_be    = 4'b1111;
                ram_wdata = acc_wdata;
            end
        endcase
    end

    dm_byte_ram #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .idx_i   (ram_idx),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Request capture at acceptance; later input changes cannot disturb the access.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q  <= addr_i[LOC_W-1:0];
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            wdata_q <= data_i;
        end
    end

    // Handshake FSM: wait-state counter, registered ack/err and the load result register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        state_q <= WAIT;
                        if (req_err) begin
                            ack_q <= 1'b1;
                            err_q <= 1'b1;
                            cnt_q <= 4'd0;
                        end else if (LATENCY == 0) begin
                            ack_q <= 1'b1;
                            cnt_q <= 4'd0;
                        end else begin
                            cnt_q <= LAT;
                        end
                    end
                end
                WAIT: begin
                    if (ack_q) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end else if (cnt_q == 4'd1) begin
                        ack_q <= 1'b1;
                        cnt_q <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (fire && !acc_we) begin
                load_q <= extend_load(load_raw, acc_size, acc_uns);
            end
        end
    end

    assign busy_o = (state_q == WAIT);
    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign data_o = load_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (LATENCY 0, 2, 15) sharing operand inputs,
// each with its own request line, checked against a byte-array reference model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 1024;

    typedef struct {
        bit          we;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          err;
        logic [31:0] ld;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_v [3];
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        busy_v [3];
    logic        ack_v [3];
    logic        err_v [3];
    logic [31:0] dout_v [3];

    int          total = 0;
    int          bad = 0;
    int          lat [3] = '{0, 2, 15};
    logic [31:0] last_data [3];
    logic [7:0]  mdl [3][DEPTH];

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(0), .ADDR_W(32)) dut_l0 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req_v[0]), .we_i(we), .size_i(sz),
        .unsigned_i(uns), .addr_i(addr), .data_i(wd), .busy_o(busy_v[0]),
        .ack_o(ack_v[0]), .err_o(err_v[0]), .data_o(dout_v[0]));

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(2), .ADDR_W(32)) dut_l2 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req_v[1]), .we_i(we), .size_i(sz),
        .unsigned_i(uns), .addr_i(addr), .data_i(wd), .busy_o(busy_v[1]),
        .ack_o(ack_v[1]), .err_o(err_v[1]), .data_o(dout_v[1]));

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(15), .ADDR_W(32)) dut_l15 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req_v[2]), .we_i(we), .size_i(sz),
        .unsigned_i(uns), .addr_i(addr), .data_i(wd), .busy_o(busy_v[2]),
        .ack_o(ack_v[2]), .err_o(err_v[2]), .data_o(dout_v[2]));

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic int nbytes(logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    // Legality from the access rules: size, natural alignment, fit inside the array.
    function automatic bit model_err(logic [1:0] s, logic [31:0] a);
        longint n;
        if (s == 2'b11) return 1'b1;
        n = longint'(nbytes(s));
        if ((longint'(a) % n) != 0) return 1'b1;
        if (longint'(a) + n > DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(int sel, logic [1:0] s, bit u, logic [31:0] a);
        longint n;
        longint v;
        n = longint'(nbytes(s));
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mdl[sel][a + i]) << (8 * i);
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic void model_store(int sel, logic [1:0] s, logic [31:0] a, logic [31:0] d);
        int n;
        n = nbytes(s);
        for (int i = 0; i < n; i++) mdl[sel][a + i] = d[8*i +: 8];
    endfunction

    // One complete transaction: request, scramble inputs, follow the cycle count to the ack.
    task automatic run_access(input int sel, input bit w, input logic [1:0] s, input bit u,
                              input logic [31:0] a, input logic [31:0] d, input bit e,
                              input logic [31:0] ld, input string nm);
        int          exp_cyc;
        bit          got;
        logic [31:0] exp_dout;
        exp_dout = (!w && !e) ? ld : last_data[sel];
        exp_cyc  = e ? 1 : lat[sel] + 1;
        @(posedge clk); #1;
        we = w; sz = s; uns = u; addr = a; wd = d; req_v[sel] = 1'b1;
        @(posedge clk); #1;
        req_v[sel] = 1'b0;
        we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom); addr = $urandom; wd = $urandom;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            check({nm, " busy_in_flight"}, 32'(busy_v[sel]), 32'd1);
            if (ack_v[sel]) begin
                got = 1'b1;
                check({nm, " ack_cycle"}, 32'(c), 32'(exp_cyc));
                check({nm, " err"}, 32'(err_v[sel]), 32'(e));
                check({nm, " data"}, dout_v[sel], exp_dout);
            end
        end
        if (!got) check({nm, " ack_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        check({nm, " busy_after"}, 32'(busy_v[sel]), 32'd0);
        check({nm, " ack_after"}, 32'(ack_v[sel]), 32'd0);
        if (!w && !e) last_data[sel] = ld;
        if (w && !e) model_store(sel, s, a, d);
    endtask

    // Reset asserted during cycle rc of a store of all-ones to 0x20 on the LATENCY=2 instance.
    task automatic reset_mid_store(input int rc, input string nm);
        @(posedge clk); #1;
        we = 1'b1; sz = 2'b10; uns = 1'b0; addr = 32'h20; wd = 32'hFFFF_FFFF; req_v[1] = 1'b1;
        @(posedge clk); #1;
        req_v[1] = 1'b0;
        for (int c = 1; c < rc; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check({nm, " no_ack"}, 32'(ack_v[1]), 32'd0);
        end
        check({nm, " busy"}, 32'(busy_v[1]), 32'd0);
        check({nm, " data_reset"}, dout_v[1], 32'h0);
        for (int i = 0; i < 3; i++) last_data[i] = 32'h0;
    endtask

    initial begin
        vec_t        tbl [$];
        vec_t        tbl_t [$];
        logic [31:0] expq [$];
        int          last_ack;
        int          nack;
        int          r;
        bit          w;
        bit          u;
        bit          e;
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ld;

        // Directed vectors for the LATENCY=2 instance.
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h04,       32'hCAFE_BABE, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h08,       32'h1122_3344, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h20,       32'h0102_0304, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h10,       32'h8BAD_F00D, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,         1'b0, 32'h8BAD_F00D});
        tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h13,       32'h0,         1'b0, 32'hFFFF_FF8B});
        tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h13,       32'h0,         1'b0, 32'h0000_008B});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h10,       32'h0,         1'b0, 32'hFFFF_F00D});
        tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h12,       32'h0,         1'b0, 32'h0000_8BAD});
        tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h11,       32'hFFFF_FF5A, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,         1'b0, 32'h8BAD_5A0D});
        tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h06,       32'h1234_5678, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h04,       32'h0,         1'b0, 32'hCAFE_BABE});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h08,       32'h0,         1'b0, 32'h1122_3344});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h3FE,      32'h0,         1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'b11, 1'b0, 32'h10,       32'h0,         1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'h0,        1'b1, 32'h0});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h3FE,      32'h0000_9ABC, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h3FE,      32'h0,         1'b0, 32'hFFFF_9ABC});
        tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h3FF,      32'h0,         1'b0, 32'h0000_009A});
        tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h11,       32'hAAAA_AAAA, 1'b1, 32'h0});
        tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,         1'b0, 32'h8BAD_5A0D});

        // Timing vectors shared by the LATENCY=0 and LATENCY=15 instances.
        tbl_t.push_back('{1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5_0F0F, 1'b0, 32'h0});
        tbl_t.push_back('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         1'b0, 32'hA5A5_0F0F});
        tbl_t.push_back('{1'b0, 2'b00, 1'b0, 32'h41, 32'h0,         1'b0, 32'h0000_000F});
        tbl_t.push_back('{1'b0, 2'b01, 1'b0, 32'h42, 32'h0,         1'b0, 32'hFFFF_A5A5});
        tbl_t.push_back('{1'b0, 2'b10, 1'b0, 32'h42, 32'h0,         1'b1, 32'h0});
        tbl_t.push_back('{1'b1, 2'b11, 1'b0, 32'h40, 32'h0,         1'b1, 32'h0});

        for (int i = 0; i < 3; i++) begin
            req_v[i]     = 1'b0;
            last_data[i] = 32'h0;
        end
        we = 1'b0; sz = 2'b00; uns = 1'b0; addr = 32'h0; wd = 32'h0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset busy%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("reset ack%0d", i), 32'(ack_v[i]), 32'd0);
            check($sformatf("reset data%0d", i), dout_v[i], 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i])
            run_access(1, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
                       tbl[i].err, tbl[i].ld, $sformatf("vec%0d", i));

        foreach (tbl_t[i]) begin
            run_access(0, tbl_t[i].we, tbl_t[i].sz, tbl_t[i].uns, tbl_t[i].addr, tbl_t[i].wd,
                       tbl_t[i].err, tbl_t[i].ld, $sformatf("lat0_vec%0d", i));
            run_access(2, tbl_t[i].we, tbl_t[i].sz, tbl_t[i].uns, tbl_t[i].addr, tbl_t[i].wd,
                       tbl_t[i].err, tbl_t[i].ld, $sformatf("lat15_vec%0d", i));
        end

        // Randomised traffic against the reference model, region 0x100..0x1FF preloaded first.
        for (int sel = 0; sel < 3; sel++) begin
            for (int i = 0; i < 64; i++) begin
                a = 32'h100 + 32'(4 * i);
                run_access(sel, 1'b1, 2'b10, 1'b0, a, $urandom, model_err(2'b10, a), 32'h0,
                           $sformatf("init%0d", sel));
            end
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 9);
                s = 2'($urandom_range(0, 2));
                a = 32'h100 + 32'($urandom_range(0, 255));
                if (r == 0) s = 2'b11;
                else if (r == 1) a = (($urandom & 1) != 0) ? 32'h8000_0100
                                                            : 32'(DEPTH) + 32'($urandom_range(0, 7));
                w  = 1'($urandom);
                u  = 1'($urandom);
                d  = $urandom;
                e  = model_err(s, a);
                ld = (!w && !e) ? model_load(sel, s, u, a) : 32'h0;
                run_access(sel, w, s, u, a, d, e, ld, $sformatf("rand%0d_%0d", sel, i));
            end
        end

        // Request held high with a new address every cycle on the LATENCY=2 instance.
        last_ack = -1;
        nack     = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (c < 24) begin
                req_v[1] = 1'b1; we = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h100 + 32'(4 * c);
            end else begin
                req_v[1] = 1'b0;
            end
            @(negedge clk);
            if (ack_v[1]) begin
                nack++;
                if (expq.size() == 0) begin
                    check("burst unexpected_ack", 32'd1, 32'd0);
                end else begin
                    last_data[1] = expq.pop_front();
                    check("burst data", dout_v[1], last_data[1]);
                end
                if (last_ack >= 0) check("burst spacing", 32'(c - last_ack), 32'(lat[1] + 2));
                last_ack = c;
            end
            if (!busy_v[1] && req_v[1]) expq.push_back(model_load(1, 2'b10, 1'b0, addr));
        end
        check("burst ack_count", 32'(nack), 32'd6);
        check("burst pending", 32'(expq.size()), 32'd0);

        // Reset in the first wait cycle, then on the completion edge itself.
        reset_mid_store(1, "rst_cyc1");
        run_access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0102_0304, "rst_cyc1 reload");
        reset_mid_store(2, "rst_cyc2");
        run_access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0102_0304, "rst_cyc2 reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
